// File: rtl/rx_prbs_mon.sv
// PRBS link monitor for the receive byte stream: hunt/lock synchroniser,
// windowed bit-error and word-rate measurement, saturating cumulative counters.
module rx_prbs_mon #(
  parameter int unsigned pDAT_W     = 8,
  parameter int unsigned pMSB_FIRST = 0,
  parameter int unsigned pERR_W     = 24,
  parameter int unsigned pWIN_W     = 24,
  parameter int unsigned pLOCK_N    = 16,
  parameter int unsigned pLOSS_N    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [1:0]        prbs_sel,
  input  logic [pWIN_W-1:0] win_len,
  input  logic              ival,
  input  logic [pDAT_W-1:0] idat,
  output logic              lock,
  output logic              o_upd,
  output logic [pERR_W-1:0] o_err_win,
  output logic [pERR_W-1:0] o_word_win,
  output logic [pERR_W-1:0] o_err_tot,
  output logic [15:0]       o_loss_cnt
);

  localparam int unsigned LFSR_W = 23;
  localparam int unsigned PC_W   = $clog2(pDAT_W) + 1;
  localparam int unsigned IDX_W  = (pDAT_W > 1) ? $clog2(pDAT_W) : 1;
  localparam int unsigned SUM_W  = ((pERR_W > PC_W) ? pERR_W : PC_W) + 1;
  localparam int unsigned GR_W   = $clog2(pLOCK_N + 1);
  localparam int unsigned BR_W   = $clog2(pLOSS_N + 1);
  localparam logic [pERR_W-1:0] ERR_MAX = '1;

  typedef enum logic {ST_HUNT = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d, lfsr_w;
  logic [1:0]          sel_q;
  logic [GR_W-1:0]     good_q, good_d;
  logic [BR_W-1:0]     bad_q, bad_d;
  logic [pWIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [pERR_W-1:0]   acc_err_q, acc_err_d, acc_word_q, acc_word_d;
  logic [pERR_W-1:0]   err_win_d, word_win_d, err_tot_d;
  logic [15:0]         loss_d;
  logic                upd_d;
  logic [pDAT_W-1:0]   pred;
  logic [IDX_W-1:0]    pos;
  logic [PC_W-1:0]     errs;
  logic [SUM_W-1:0]    err_c, word_c;
  logic                mis, sel_chg, hunt, zero_reg, good, win_on, win_last;

  // Next PRBS bit from the bit history (bit 0 = most recent bit).
  function automatic logic tap(input logic [LFSR_W-1:0] r, input logic [1:0] sel);
    case (sel)
      2'd0:    return r[6] ^ r[5];
      2'd1:    return r[14] ^ r[13];
      default: return r[22] ^ r[17];
    endcase
  endfunction

  function automatic logic [LFSR_W-1:0] sel_mask(input logic [1:0] sel);
    case (sel)
      2'd0:    return LFSR_W'(23'h00007F);
      2'd1:    return LFSR_W'(23'h007FFF);
      default: return '1;
    endcase
  endfunction

  function automatic logic [pERR_W-1:0] sat_add(input logic [pERR_W-1:0] a,
                                                input logic [SUM_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + b;
    if (s > SUM_W'(ERR_MAX)) return ERR_MAX;
    return s[pERR_W-1:0];
  endfunction

  assign sel_chg  = (prbs_sel != sel_q);
  assign hunt     = (state_q == ST_HUNT) || sel_chg;
  assign zero_reg = ((lfsr_q & sel_mask(prbs_sel)) == '0);
  assign good     = !mis && (idat != '0) && !zero_reg;
  assign win_on   = (win_len != '0);
  assign win_last = win_on && (win_cnt_q >= (win_len - pWIN_W'(1)));
  assign err_c    = (ival && !hunt) ? SUM_W'(errs) : '0;
  assign word_c   = SUM_W'(ival);

  // Bit-serial walk: hunting loads received bits, locked free-runs on predictions.
  always_comb begin : walk
    lfsr_w = lfsr_q;
    pred   = '0;
    mis    = 1'b0;
    pos    = '0;
    for (int i = 0; i < int'(pDAT_W); i++) begin
      pos       = (pMSB_FIRST != 0) ? IDX_W'(int'(pDAT_W) - 1 - i) : IDX_W'(i);
      pred[pos] = tap(lfsr_w, prbs_sel);
      mis       = mis | (pred[pos] ^ idat[pos]);
      lfsr_w    = {lfsr_w[LFSR_W-2:0], hunt ? idat[pos] : pred[pos]};
    end
    errs = PC_W'($countones(idat ^ pred));
  end

  // Synchronisation FSM next-state and run counters.
  always_comb begin : fsm
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    loss_d  = o_loss_cnt;
    lfsr_d  = ival ? lfsr_w : lfsr_q;
    if (sel_chg) begin
      state_d = ST_HUNT;
      good_d  = '0;
      bad_d   = '0;
      if (state_q == ST_LOCK && o_loss_cnt != '1) loss_d = o_loss_cnt + 16'd1;
    end else if (ival) begin
      case (state_q)
        ST_HUNT: begin
          if (!good) begin
            good_d = '0;
          end else if (good_q == GR_W'(pLOCK_N - 1)) begin
            state_d = ST_LOCK;
            good_d  = '0;
          end else begin
            good_d = good_q + GR_W'(1);
          end
        end
        default: begin
          if (errs == '0) begin
            bad_d = '0;
          end else if (bad_q == BR_W'(pLOSS_N - 1)) begin
            state_d = ST_HUNT;
            bad_d   = '0;
            if (o_loss_cnt != '1) loss_d = o_loss_cnt + 16'd1;
          end else begin
            bad_d = bad_q + BR_W'(1);
          end
        end
      endcase
    end
    if (clr) begin
      state_d = ST_HUNT;
      good_d  = '0;
      bad_d   = '0;
      loss_d  = '0;
      lfsr_d  = '0;
    end
  end

  // Window counter, accumulators and result capture.
  always_comb begin : meas
    acc_err_d  = sat_add(acc_err_q, err_c);
    acc_word_d = sat_add(acc_word_q, word_c);
    err_tot_d  = sat_add(o_err_tot, err_c);
    err_win_d  = o_err_win;
    word_win_d = o_word_win;
    upd_d      = 1'b0;
    win_cnt_d  = win_cnt_q + pWIN_W'(1);
    if (!win_on) begin
      win_cnt_d = '0;
    end else if (win_last) begin
      win_cnt_d  = '0;
      err_win_d  = acc_err_d;
      word_win_d = acc_word_d;
      acc_err_d  = '0;
      acc_word_d = '0;
      upd_d      = 1'b1;
    end
    if (clr) begin
      acc_err_d  = '0;
      acc_word_d = '0;
      err_tot_d  = '0;
      err_win_d  = '0;
      word_win_d = '0;
      upd_d      = 1'b0;
      win_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_HUNT;
      lfsr_q     <= '0;
      sel_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      win_cnt_q  <= '0;
      acc_err_q  <= '0;
      acc_word_q <= '0;
      lock       <= 1'b0;
      o_upd      <= 1'b0;
      o_err_win  <= '0;
      o_word_win <= '0;
      o_err_tot  <= '0;
      o_loss_cnt <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      sel_q      <= clr ? 2'd0 : prbs_sel;
      good_q     <= good_d;
      bad_q      <= bad_d;
      win_cnt_q  <= win_cnt_d;
      acc_err_q  <= acc_err_d;
      acc_word_q <= acc_word_d;
      lock       <= (state_d == ST_LOCK);
      o_upd      <= upd_d;
      o_err_win  <= err_win_d;
      o_word_win <= word_win_d;
      o_err_tot  <= err_tot_d;
      o_loss_cnt <= loss_d;
    end
  end

endmodule

// File: tb/tb_rx_prbs_mon.sv
// Directed bench for rx_prbs_mon: two instances (24-bit and 4-bit counters)
// driven with the same PRBS streams, checked with immediate assertions.
module tb_rx_prbs_mon;

  logic        clk = 1'b0;
  logic        rst, clr, ival;
  logic [1:0]  prbs_sel;
  logic [23:0] win_len;
  logic [7:0]  idat;

  logic        lock_a, upd_a;
  logic [23:0] err_win_a, word_win_a, err_tot_a;
  logic [15:0] loss_a;
  logic        lock_b, upd_b;
  logic [3:0]  err_win_b, word_win_b, err_tot_b;
  logic [15:0] loss_b;

  int          checks = 0;
  int          errors = 0;
  logic [22:0] g;
  int          ord;

  always #5 clk = ~clk;

  rx_prbs_mon #(.pDAT_W(8), .pMSB_FIRST(0), .pERR_W(24), .pWIN_W(24),
                .pLOCK_N(16), .pLOSS_N(8)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .prbs_sel(prbs_sel), .win_len(win_len),
    .ival(ival), .idat(idat), .lock(lock_a), .o_upd(upd_a), .o_err_win(err_win_a),
    .o_word_win(word_win_a), .o_err_tot(err_tot_a), .o_loss_cnt(loss_a));

  rx_prbs_mon #(.pDAT_W(8), .pMSB_FIRST(0), .pERR_W(4), .pWIN_W(24),
                .pLOCK_N(16), .pLOSS_N(8)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .prbs_sel(prbs_sel), .win_len(win_len),
    .ival(ival), .idat(idat), .lock(lock_b), .o_upd(upd_b), .o_err_win(err_win_b),
    .o_word_win(word_win_b), .o_err_tot(err_tot_b), .o_loss_cnt(loss_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference stream generator, LSB of each byte is the earliest bit.
  task automatic gen(output logic [7:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      case (ord)
        7:       b = g[6] ^ g[5];
        15:      b = g[14] ^ g[13];
        default: b = g[22] ^ g[17];
      endcase
      g    = {g[21:0], b};
      w[i] = b;
    end
  endtask

  // Advance the generator to a point where the next 24 bytes are all non-zero.
  task automatic find_clean();
    logic [22:0] s;
    logic [7:0]  w;
    logic        ok;
    for (int t = 0; t < 500; t++) begin
      s  = g;
      ok = 1'b1;
      for (int k = 0; k < 24; k++) begin
        gen(w);
        if (w == 8'h00) ok = 1'b0;
      end
      g = s;
      if (ok) break;
      gen(w);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    ival = v;
    idat = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n;
    int          bad;
    int          exp_tot;
    logic        exp_lock;
    logic        seen;
    logic        nz;
    logic [7:0]  w;

    rst = 1'b0; clr = 1'b0; ival = 1'b0; idat = '0;
    prbs_sel = 2'd2; win_len = '0; ord = 23; g = 23'h1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lock", 32'(lock_a), 0);
    chk("rst_upd", 32'(upd_a), 0);
    chk("rst_err_tot", 32'(err_tot_a), 0);
    chk("rst_loss", 32'(loss_a), 0);
    chk("rst_err_win", 32'(err_win_a), 0);
    chk("rst_word_win", 32'(word_win_a), 0);

    rst = 1'b1;
    nz = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      step(1'b0, 8'h00);
      if (lock_a || upd_a || err_tot_a != 0 || err_win_a != 0 || word_win_a != 0 || loss_a != 0)
        nz = 1'b1;
    end
    chk("idle_outputs_nonzero", 32'(nz), 0);

    // PRBS23 acquisition
    find_clean();
    n = 0;
    while (lock_a !== 1'b1 && n < 40) begin
      gen(w); step(1'b1, w); n++;
    end
    chk("lock23_by_19", 32'(n <= 19), 1);
    chk("lock23_min_17", 32'(n >= 17), 1);
    chk("lock23", 32'(lock_a), 1);
    repeat (10) begin gen(w); step(1'b1, w); end
    chk("lock23_err_tot", 32'(err_tot_a), 0);

    // Windowing with one flipped bit
    win_len = 24'd100;
    seen = 1'b0; n = 0;
    while (!seen && n < 250) begin
      gen(w); step(1'b1, w); n++;
      seen = (upd_a === 1'b1);
    end
    chk("win_sync", 32'(seen), 1);
    for (int k = 1; k <= 100; k++) begin
      gen(w);
      if (k == 50) w = w ^ 8'h08;
      step(1'b1, w);
      if (k == 99) chk("win1_upd_early", 32'(upd_a), 0);
    end
    chk("win1_upd", 32'(upd_a), 1);
    chk("win1_err", 32'(err_win_a), 1);
    chk("win1_words", 32'(word_win_a), 100);
    chk("win1_err_tot", 32'(err_tot_a), 1);
    exp_tot = 1;
    for (int k = 1; k <= 100; k++) begin gen(w); step(1'b1, w); end
    chk("win2_upd", 32'(upd_a), 1);
    chk("win2_err", 32'(err_win_a), 0);
    chk("win2_words", 32'(word_win_a), 100);
    chk("win2_lock", 32'(lock_a), 1);

    // Loss of lock on all-zero words; hunting must not lock on zeros
    exp_lock = 1'b1; bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (exp_lock) begin
        gen(w);
        exp_tot += $countones(w);
        if (w != 8'h00) bad++; else bad = 0;
        if (bad == 8) exp_lock = 1'b0;
      end
      step(1'b1, 8'h00);
      chk("loss_lock", 32'(lock_a), 32'(exp_lock));
    end
    chk("loss_cnt1", 32'(loss_a), 1);
    chk("loss_err_tot", 32'(err_tot_a), 32'(exp_tot));

    // PRBS7 acquisition from a zero register
    prbs_sel = 2'd0; ord = 7; g = 23'h5B;
    n = 0;
    while (lock_a !== 1'b1 && n < 40) begin
      gen(w); step(1'b1, w); n++;
    end
    chk("lock7_words", 32'(n), 17);
    repeat (5) begin gen(w); step(1'b1, w); end
    chk("lock7_hold", 32'(lock_a), 1);
    chk("lock7_err_tot", 32'(err_tot_a), 32'(exp_tot));

    // Switch to PRBS15 while locked
    ord = 15; g = 23'h1ACE; find_clean();
    prbs_sel = 2'd1;
    gen(w); step(1'b1, w);
    chk("switch_drop", 32'(lock_a), 0);
    chk("switch_loss_cnt", 32'(loss_a), 2);
    n = 1;
    while (lock_a !== 1'b1 && n < 40) begin
      gen(w); step(1'b1, w); n++;
    end
    chk("lock15_by_18", 32'(n <= 18), 1);
    chk("lock15_min_17", 32'(n >= 17), 1);

    // clr with a valid word in the same cycle
    clr = 1'b1;
    gen(w); step(1'b1, w);
    clr = 1'b0;
    chk("clr1_lock", 32'(lock_a), 0);
    chk("clr1_err_tot", 32'(err_tot_a), 0);
    chk("clr1_loss", 32'(loss_a), 0);
    chk("clr1_word_win", 32'(word_win_a), 0);
    chk("clr1_loss_b", 32'(loss_b), 0);
    chk("clr1_err_tot_b", 32'(err_tot_b), 0);

    // Relock on PRBS15, then 3 errored bits per word
    n = 0;
    while (lock_a !== 1'b1 && n < 40) begin
      gen(w); step(1'b1, w); n++;
    end
    chk("relock15_by_18", 32'(n <= 18), 1);
    chk("relock15_err_tot", 32'(err_tot_a), 0);
    repeat (4) begin gen(w); step(1'b1, w ^ 8'h15); end
    chk("sat_a_12", 32'(err_tot_a), 12);
    chk("sat_b_12", 32'(err_tot_b), 12);
    repeat (2) begin gen(w); step(1'b1, w ^ 8'h15); end
    chk("sat_a_18", 32'(err_tot_a), 18);
    chk("sat_b_15", 32'(err_tot_b), 15);
    gen(w); step(1'b1, w);
    chk("sat_b_stick", 32'(err_tot_b), 15);
    chk("sat_lock_a", 32'(lock_a), 1);
    chk("sat_lock_b", 32'(lock_b), 1);

    // Final clr pulse
    clr = 1'b1;
    step(1'b0, 8'h00);
    clr = 1'b0;
    chk("clr2_lock_a", 32'(lock_a), 0);
    chk("clr2_err_tot_a", 32'(err_tot_a), 0);
    chk("clr2_err_win_a", 32'(err_win_a), 0);
    chk("clr2_upd_a", 32'(upd_a), 0);
    chk("clr2_lock_b", 32'(lock_b), 0);
    chk("clr2_err_tot_b", 32'(err_tot_b), 0);
    chk("clr2_err_win_b", 32'(err_win_b), 0);
    chk("clr2_word_win_b", 32'(word_win_b), 0);
    chk("clr2_upd_b", 32'(upd_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
